// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the scanned seven-segment display driver.
// Segment patterns are active-low {a,b,c,d,e,f,g}, with a as the MSB.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_DECODE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Counter/index width that stays legal when the range collapses to one value.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_DECODE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver with a double-buffered
// value, per-digit blanking, leading-zero suppression and whole-display blink.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank_en,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DIG_W = idx_width(NUM_DIGITS);
    localparam int DIV_W = idx_width(REFRESH_DIV);
    localparam int BLK_W = idx_width(BLINK_DIV);

    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;
    logic [DIV_W-1:0]        div_cnt;
    logic [DIG_W-1:0]        dig;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_on;

    logic                    slot_end;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic                    upper_zero;
    logic [3:0]              cur_nibble;
    logic                    cur_dark;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    seg_t                    cur_seg;

    assign slot_end   = (div_cnt == DIV_LAST);
    assign frame_wrap = slot_end && (dig == DIG_LAST);

    // NOTE: every signal gets a default before the loops so no latch is inferred.
    always_comb begin
        lz_dark    = '0;
        upper_zero = 1'b1;
        cur_nibble = '0;
        cur_dark   = 1'b0;
        cur_onehot = '1;

        // A digit is a leading zero when it and every digit above it are zero.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (active[4*k +: 4] == 4'h0);
            lz_dark[k] = lz_blank_en && (k != 0) && upper_zero;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig == DIG_W'(k)) begin
                cur_nibble    = active[4*k +: 4];
                cur_dark      = blank_mask[k] || lz_dark[k];
                cur_onehot[k] = 1'b0;
            end
        end

        cur_dark = cur_dark || (blink_en && !blink_on);
    end

    hex_seg_lut u_hex_seg_lut (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // NOTE: non-blocking assignments, so every register samples the pre-edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            active    <= '0;
            div_cnt   <= '0;
            dig       <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (load) begin
                pending <= value;
            end

            if (slot_end) begin
                div_cnt <= '0;
                dig     <= frame_wrap ? '0 : dig + DIG_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // The displayed buffer only changes between frames, so no digit tears.
            if (frame_wrap) begin
                active <= load ? value : pending;
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // seg and an load on the same edge from the same digit, so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (cur_dark) begin
                seg <= SEG_BLANK;
                an  <= '1;
            end else begin
                seg <= cur_seg;
                an  <= cur_onehot;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        lz_blank_en;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .lz_blank_en (lz_blank_en),
        .blink_en    (blink_en),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Per-digit expectations, index 0 = rightmost digit (an = 1110).
    typedef struct {
        logic [15:0]      value;
        logic             lz;
        logic [3:0]       mask;
        logic [3:0][3:0]  an_exp;
        logic [3:0][6:0]  seg_exp;
    } vec_t;

    localparam logic [15:0] AN_ALL  = 16'h7BDE;
    localparam logic [15:0] AN_DARK = 16'hFFFF;
    localparam logic [27:0] SEG_ZEROS = {7'h01, 7'h01, 7'h01, 7'h01};
    localparam logic [27:0] SEG_DARK  = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Checks one whole frame starting at the negedge after its first edge; ends on
    // the negedge where frame_done is high. Optionally pulses load after cycle load_at.
    task automatic check_frame(input string tag, input logic [3:0][3:0] an_exp,
                               input logic [3:0][6:0] seg_exp, input int load_at,
                               input logic [15:0] load_val);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            check($sformatf("%s an c%0d", tag, n), 16'(an), 16'(an_exp[n/4]));
            check($sformatf("%s seg c%0d", tag, n), 16'(seg), 16'(seg_exp[n/4]));
            check($sformatf("%s frame_done c%0d", tag, n), 16'(frame_done),
                  (n == 15) ? 16'd1 : 16'd0);
            if (n == load_at) begin
                value = load_val;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic skip_frame();
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h1A3F, 1'b0, 4'b0000, AN_ALL,   {7'h4F, 7'h08, 7'h06, 7'h38}};
        vecs[1] = '{16'h0040, 1'b1, 4'b0000, 16'hFFDE, {7'h7F, 7'h7F, 7'h4C, 7'h01}};
        vecs[2] = '{16'h0000, 1'b1, 4'b0000, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[3] = '{16'h0000, 1'b0, 4'b0000, AN_ALL,   SEG_ZEROS};
        vecs[4] = '{16'h1A3F, 1'b0, 4'b0010, 16'h7BFE, {7'h4F, 7'h08, 7'h7F, 7'h38}};
        vecs[5] = '{16'h8765, 1'b1, 4'b0000, AN_ALL,   {7'h00, 7'h0F, 7'h20, 7'h24}};
        vecs[6] = '{16'h0B0C, 1'b1, 4'b0000, 16'hFBDE, {7'h7F, 7'h60, 7'h01, 7'h31}};
        vecs[7] = '{16'h9ED4, 1'b0, 4'b1001, 16'hFBDF, {7'h7F, 7'h30, 7'h42, 7'h7F}};
        vecs[8] = '{16'h2000, 1'b1, 4'b0000, AN_ALL,   {7'h12, 7'h01, 7'h01, 7'h01}};

        reset       = 1'b1;
        load        = 1'b0;
        value       = 16'h0;
        blank_mask  = 4'h0;
        lz_blank_en = 1'b0;
        blink_en    = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset an c%0d", c), 16'(an), 16'hF);
            check($sformatf("reset seg c%0d", c), 16'(seg), 16'h7F);
            check($sformatf("reset frame_done c%0d", c), 16'(frame_done), 16'h0);
        end
        reset = 1'b0;

        check_frame("post_reset", AN_ALL, SEG_ZEROS, -1, 16'h0);

        // Each vector is loaded at a wrap boundary; the next frame still shows the old
        // buffer and the one after shows the new value.
        for (int i = 0; i < 9; i++) begin
            value       = vecs[i].value;
            load        = 1'b1;
            lz_blank_en = vecs[i].lz;
            blank_mask  = vecs[i].mask;
            skip_frame();
            check_frame($sformatf("vec%0d", i), vecs[i].an_exp, vecs[i].seg_exp, -1, 16'h0);
        end

        // Double buffer: mid-frame load stays hidden until the next frame.
        lz_blank_en = 1'b0;
        blank_mask  = 4'h0;
        check_frame("dbuf_old", AN_ALL, {7'h12, 7'h01, 7'h01, 7'h01}, 6, 16'h0002);
        // Load on the wrap cycle itself is shown in the very next frame.
        check_frame("dbuf_new", AN_ALL, {7'h01, 7'h01, 7'h01, 7'h12}, 14, 16'h0005);
        check_frame("wrap_load", AN_ALL, {7'h01, 7'h01, 7'h01, 7'h24}, -1, 16'h0);

        // Mid-frame reset with a load pending: outputs clear at once, the load is lost.
        repeat (3) @(negedge clk);
        value = 16'h0007;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        blink_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("midreset an c%0d", c), 16'(an), 16'hF);
            check($sformatf("midreset seg c%0d", c), 16'(seg), 16'h7F);
            check($sformatf("midreset frame_done c%0d", c), 16'(frame_done), 16'h0);
        end
        reset = 1'b0;

        // Blink with BLINK_DIV=2: two frames lit, two dark, repeating.
        check_frame("blink_f0", AN_ALL,  SEG_ZEROS, -1, 16'h0);
        check_frame("blink_f1", AN_ALL,  SEG_ZEROS, -1, 16'h0);
        check_frame("blink_f2", AN_DARK, SEG_DARK,  -1, 16'h0);
        check_frame("blink_f3", AN_DARK, SEG_DARK,  -1, 16'h0);
        check_frame("blink_f4", AN_ALL,  SEG_ZEROS, -1, 16'h0);
        check_frame("blink_f5", AN_ALL,  SEG_ZEROS, -1, 16'h0);

        // Dark frame 6: dropping blink_en mid-frame relights on the following cycle.
        for (int n = 0; n < 16; n++) begin
            logic [3:0] an_want;
            logic [3:0] onehot;
            @(negedge clk);
            onehot  = ~(4'b0001 << (n / 4));
            an_want = (n < 8) ? 4'hF : onehot;
            check($sformatf("unblink an c%0d", n), 16'(an), 16'(an_want));
            check($sformatf("unblink seg c%0d", n), 16'(seg), (n < 8) ? 16'h7F : 16'h01);
            check($sformatf("unblink frame_done c%0d", n), 16'(frame_done),
                  (n == 15) ? 16'd1 : 16'd0);
            if (n == 7) begin
                blink_en = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
